fp_adder_arbiter: RTL and testbench

FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

---
 rtl/fp_adder_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fp_adder_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_arbiter.sv
// -----------------------------------------------------------------------------
// fp_adder_arbiter
// Shares one strobe/ack FP32 adder between NREQ requesters using a
// round-robin arbiter. Operands are latched at grant and handed to the adder
// through two strobe/ack handshakes. The adder result is then captured and
// returned with a one-cycle Done pulse to the granted requester.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : per-requester request, held until its done bit pulses
//   op_a/op_b  : packed operands, requester i at [i*DW +: DW]
//   done       : one-hot, one-cycle completion pulse
//   result     : adder sum for the last completed operation
//   busy       : high from grant through the done cycle
//   owner      : index of the current or last granted requester
//   add_a/add_b, add_a_stb/add_b_stb, add_a_ack/add_b_ack : operand side
//   add_z, add_z_stb, add_z_ack                            : result side
//
// State table
//   state  | meaning
//   IDLE   | arbitrate; on grant latch operands and raise add_a_stb
//   SEND_A | hold add_a_stb until add_a_ack
//   SEND_B | hold add_b_stb until add_b_ack
//   WAIT_Z | wait for add_z_stb, capture result, pulse ack and done
//   RESP   | done/ack pulse cycle; release busy, record last owner
// -----------------------------------------------------------------------------
module fp_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] op_a,
    input  logic [NREQ*DW-1:0] op_b,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      result,
    output logic               busy,
    output logic [OW-1:0]      owner,
    output logic [DW-1:0]      add_a,
    output logic [DW-1:0]      add_b,
    output logic               add_a_stb,
    output logic               add_b_stb,
    input  logic               add_a_ack,
    input  logic               add_b_ack,
    input  logic [DW-1:0]      add_z,
    input  logic               add_z_stb,
    output logic               add_z_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t          state;
    logic [OW-1:0]   last;
    logic [OW-1:0]   grant_idx;
    logic            grant_vld;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;

    // Round-robin search starting at last+1. Walking the offsets from the
    // farthest to the nearest lets the nearest set request win without a break.
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NREQ;
            cand = OW'(idx);
            if (req[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == OW'(i)) begin
                sel_a = op_a[i*DW +: DW];
                sel_b = op_b[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= OW'(NREQ - 1);
            owner     <= '0;
            busy      <= 1'b0;
            done      <= '0;
            result    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_a_stb <= 1'b0;
            add_b_stb <= 1'b0;
            add_z_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    add_a_stb <= 1'b0;
                    add_b_stb <= 1'b0;
                    add_z_ack <= 1'b0;
                    done      <= '0;
                    if (grant_vld) begin
                        owner     <= grant_idx;
                        add_a     <= sel_a;
                        add_b     <= sel_b;
                        busy      <= 1'b1;
                        add_a_stb <= 1'b1;
                        state     <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (add_a_ack) begin
                        add_a_stb <= 1'b0;
                        add_b_stb <= 1'b1;
                        state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (add_b_ack) begin
                        add_b_stb <= 1'b0;
                        state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (add_z_stb) begin
                        result    <= add_z;
                        add_z_ack <= 1'b1;
                        // done is registered here so it coincides with the
                        // RESP cycle, while busy is still high
                        done      <= NREQ'(1) << owner;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    add_z_ack <= 1'b0;
                    done      <= '0;
                    busy      <= 1'b0;
                    last      <= owner;
                    state     <= IDLE;
                end
                default: begin
                    add_a_stb <= 1'b0;
                    add_b_stb <= 1'b0;
                    add_z_ack <= 1'b0;
                    done      <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_adder_arbiter
// Bench for fp_adder_arbiter: behavioural FP adder on the adder side, a
// transaction-level expectation model checked every cycle, directed scenarios
// with literal expectations, then a randomized requester/adder phase.
// -----------------------------------------------------------------------------
module tb_fp_adder_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] op_a = '0;
    logic [NREQ*DW-1:0] op_b = '0;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      result;
    logic               busy;
    logic [1:0]         owner;
    logic [DW-1:0]      add_a, add_b;
    logic               add_a_stb, add_b_stb;
    logic               add_a_ack = 1'b0, add_b_ack = 1'b0;
    logic [DW-1:0]      add_z = '0;
    logic               add_z_stb = 1'b0;
    logic               add_z_ack;

    int vectors = 0;
    int miscompares = 0;

    // adder behaviour knobs: 0 ack always high, 1 random ack, 2 ack held low
    int a_mode = 0;
    int b_mode = 0;
    int zlat = 0;
    bit rand_lat = 1'b0;

    fp_adder_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .result(result), .busy(busy), .owner(owner),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z),
        .add_z_stb(add_z_stb), .add_z_ack(add_z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // FP32 add through double precision; operands are kept normal, result
    // mantissa is truncated.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int fe;
        d  = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        fe = int'(d[62:52]) - 1023 + 127;
        if (fe <= 0)   return {d[63], 31'd0};
        if (fe >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], fe[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int e;
        e = 120 + int'($urandom_range(14));
        v = $urandom;
        v[30:23] = e[7:0];
        return v;
    endfunction

    // ------------------------------------------------------------ adder BFM
    logic [31:0] cap_a = '0, cap_b = '0;
    bit          pend = 1'b0;
    int          cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            cnt  = 0;
        end else begin
            if (add_a_stb && add_a_ack) cap_a = add_a;
            if (add_b_stb && add_b_ack) begin
                cap_b = add_b;
                pend  = 1'b1;
                cnt   = rand_lat ? int'($urandom_range(3)) : zlat;
            end else if (pend && cnt > 0) begin
                cnt--;
            end
        end
        #2;
        add_a_ack = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        add_b_ack = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
        if (!rst_n) begin
            add_z_stb = 1'b0;
        end else begin
            if (add_z_ack) add_z_stb = 1'b0;
            if (pend && cnt == 0) begin
                add_z_stb = 1'b1;
                add_z     = fp_add(cap_a, cap_b);
                pend      = 1'b0;
            end
        end
    end

    // ------------------------------------------------------ reference model
    // Tracks which handshake the operation is waiting on and what each output
    // must show after the next rising edge.
    bit          m_busy, m_astb, m_bstb, m_wz, m_zack;
    int          m_owner, m_last;
    logic [3:0]  m_done;
    logic [31:0] m_result, m_a, m_b;

    function automatic int rr_pick(input int last_idx, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last_idx + k) % NREQ]) return (last_idx + k) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        int g;
        if (!rst_n) begin
            m_busy = 0; m_astb = 0; m_bstb = 0; m_wz = 0; m_zack = 0;
            m_owner = 0; m_last = NREQ - 1; m_done = '0;
            m_result = '0; m_a = '0; m_b = '0;
        end
        chk("busy",      32'(busy),      32'(m_busy));
        chk("owner",     32'(owner),     32'(m_owner));
        chk("done",      32'(done),      32'(m_done));
        chk("add_a_stb", 32'(add_a_stb), 32'(m_astb));
        chk("add_b_stb", 32'(add_b_stb), 32'(m_bstb));
        chk("add_z_ack", 32'(add_z_ack), 32'(m_zack));
        chk("add_a",     add_a,          m_a);
        chk("add_b",     add_b,          m_b);
        chk("result",    result,         m_result);
        if (rst_n) begin
            if (!m_busy) begin
                g = rr_pick(m_last, req);
                if (g >= 0) begin
                    m_owner = g;
                    m_a     = op_a[g*DW +: DW];
                    m_b     = op_b[g*DW +: DW];
                    m_busy  = 1;
                    m_astb  = 1;
                end
            end else if (m_astb) begin
                if (add_a_ack) begin m_astb = 0; m_bstb = 1; end
            end else if (m_bstb) begin
                if (add_b_ack) begin m_bstb = 0; m_wz = 1; end
            end else if (m_wz) begin
                if (add_z_stb) begin
                    m_wz     = 0;
                    m_zack   = 1;
                    m_done   = 4'(1 << m_owner);
                    m_result = fp_add(m_a, m_b);
                end
            end else begin
                m_zack = 0;
                m_done = '0;
                m_busy = 0;
                m_last = m_owner;
            end
        end
    end

    // ---------------------------------------------------------- directed
    task automatic wait_done(input string name, output int idx);
        idx = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done != '0) begin
                for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: no done within 200 cycles", name);
    endtask

    task automatic wait_busy(input string name);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (busy) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: busy never rose within 200 cycles", name);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i*DW +: DW] = a;
        op_b[i*DW +: DW] = b;
    endtask

    initial begin
        int idx;
        int order[$];
        logic [3:0] d;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_done",  32'(done),   32'd0);
        chk("rst_owner", 32'(owner),  32'd0);
        chk("rst_res",   result,      32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // single request, 1.0 + 2.0
        @(posedge clk); #1;
        set_ops(0, 32'h3F800000, 32'h40000000);
        req = 4'b0001;
        wait_done("single", idx);
        chk("single_done",  32'(done), 32'h1);
        chk("single_res",   result,    32'h40400000);
        chk("single_add_a", add_a,     32'h3F800000);
        chk("single_add_b", add_b,     32'h40000000);
        chk("single_busy",  32'(busy), 32'd1);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 32'd0);
        chk("single_done_after", 32'(done), 32'd0);

        // all four requesting continuously from a fresh reset
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, rand_fp(), rand_fp());
        zlat = 2;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done("rr", idx);
            order.push_back(idx);
        end
        @(posedge clk); #1 req = '0;
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int n = 0; n < 5 && n < order.size(); n++)
            chk("rr_order", 32'(order[n]), 32'(n % NREQ));

        // operand-A ack held low for 10 cycles
        zlat = 0;
        @(posedge clk); #1;
        a_mode = 2;
        set_ops(1, 32'h40400000, 32'h3F800000);
        req = 4'b0010;
        wait_busy("stall");
        for (int n = 0; n < 10; n++) begin
            chk("stall_a_stb", 32'(add_a_stb), 32'd1);
            chk("stall_done",  32'(done),      32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 a_mode = 0;
        wait_done("stall", idx);
        chk("stall_done_idx", 32'(idx), 32'd1);
        chk("stall_res",      result,   32'h40800000);
        @(posedge clk); #1 req = '0;

        // requester 2 drops its request and changes OpA after grant
        zlat = 3;
        @(posedge clk); #1;
        set_ops(2, 32'h3F800000, 32'h3F800000);
        req = 4'b0100;
        wait_busy("drop");
        @(posedge clk); #1;
        req = '0;
        op_a[2*DW +: DW] = 32'h41200000;
        wait_done("drop", idx);
        chk("drop_done", 32'(done), 32'h4);
        chk("drop_res",  result,    32'h40000000);

        // reset during WAIT_Z, then priority restarts at requester 0
        zlat = 8;
        @(posedge clk); #1;
        set_ops(3, 32'h3F800000, 32'h3F800000);
        set_ops(0, 32'h40000000, 32'h40000000);
        req = 4'b1000;
        wait_busy("rstmid");
        repeat (2) @(negedge clk);
        chk("rstmid_in_wait", 32'({busy, add_a_stb, add_b_stb}), 32'b100);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("rstmid_busy",  32'(busy),  32'd0);
        chk("rstmid_done",  32'(done),  32'd0);
        chk("rstmid_owner", 32'(owner), 32'd0);
        chk("rstmid_res",   result,     32'd0);
        chk("rstmid_add",   add_a | add_b, 32'd0);
        chk("rstmid_stb",   32'({add_a_stb, add_b_stb, add_z_ack}), 32'd0);
        req = 4'b1001;
        zlat = 1;
        @(posedge clk); #1 rst_n = 1'b1;
        wait_done("rstmid_first", idx);
        chk("rstmid_first_idx", 32'(idx), 32'd0);
        chk("rstmid_first_res", result,   32'h40800000);
        @(posedge clk); #1 req[0] = 1'b0;
        wait_done("rstmid_second", idx);
        chk("rstmid_second_idx", 32'(idx), 32'd3);
        @(posedge clk); #1 req = '0;

        // randomized requesters and adder timing
        a_mode = 1;
        b_mode = 1;
        rand_lat = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            d = done;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (d[i]) begin
                    req[i] = 1'($urandom_range(1));
                    if (req[i]) set_ops(i, rand_fp(), rand_fp());
                end else if (!req[i]) begin
                    if ($urandom_range(4) == 0) begin
                        req[i] = 1'b1;
                        set_ops(i, rand_fp(), rand_fp());
                    end
                end else begin
                    if ($urandom_range(39) == 0) req[i] = 1'b0;
                    if ($urandom_range(7) == 0) set_ops(i, rand_fp(), rand_fp());
                end
            end
        end
        @(posedge clk); #1 req = '0;
        a_mode = 0;
        b_mode = 0;
        begin
            bit idle_seen;
            idle_seen = 1'b0;
            for (int n = 0; n < 200 && !idle_seen; n++) begin
                @(negedge clk);
                if (!busy) idle_seen = 1'b1;
            end
            if (!idle_seen) begin
                vectors++;
                miscompares++;
                $display("FAIL drain: busy still high after 200 cycles");
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
